fft16_bfly_sched: RTL

//  Sequencer for the radix-4 butterfly in the 16-point FFT: two stages x four
//  4-input butterfly ops, run in place on an external 16-entry sample memory.

---
 rtl/fft16_bfly_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fft16_bfly_sched.sv
// fft16_bfly_sched: address/twiddle sequencer for the radix-4, in-place,
// two-stage 16-point FFT butterfly. Issues four ops per stage, delays each
// op's addresses by BF_LAT cycles for write-back, and pulses done at the end.
// Optional feature macro: FFT_SCHED_INV_EN (inverse transform: negated
// exponents and a bf_conj flag to the butterfly).
module fft16_bfly_sched #(
    parameter int BF_LAT = 2            // rd_en -> wr_en latency, >= 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
`ifdef FFT_SCHED_INV_EN
    input  logic        inverse,
    output logic        bf_conj,
`endif
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    output logic [11:0] tw_exp,
    output logic        stage,
    output logic        wr_en,
    output logic [15:0] wr_addr
);

    typedef enum logic [2:0] {IDLE, S0, W0, S1, W1} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        inv_q, inv_d;
    logic        inv_in;
    logic        issue;
    logic        last_s0;
    logic [15:0] iss_addr;
    logic [3:0]  g4, e_b, e_c, e_d;

    // write-back delay pipe; index k holds the op issued k cycles ago
    logic [BF_LAT:1]        vld_pipe;
    logic [BF_LAT:1]        last_pipe;
    logic [BF_LAT:1][15:0]  addr_pipe;

`ifdef FFT_SCHED_INV_EN
    assign inv_in  = inverse;
    assign bf_conj = rd_en & inv_q;
`else
    assign inv_in  = 1'b0;
`endif

    // (16 - e) mod 16 for the inverse transform; 0 stays 0
    function automatic logic [3:0] tw_fix(input logic [3:0] e, input logic inv);
        return inv ? 4'(4'd0 - e) : e;
    endfunction

    // state, op counter and latched direction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            inv_q   <= inv_d;
        end
    end

    // next state, issue control and status outputs
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        inv_d   = inv_q;
        issue   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        stage   = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start && !stall) begin
                    state_d = S0;
                    op_d    = '0;
                    inv_d   = inv_in;
                end
            end
            S0: if (!stall) begin
                issue = 1'b1;
                op_d  = op_q + 2'd1;
                if (op_q == 2'd3) state_d = W0;
            end
            // S1 overwrites S0 results in place: wait for the last S0 write
            W0: if (!stall && vld_pipe[BF_LAT] && last_pipe[BF_LAT]) state_d = S1;
            S1: if (!stall) begin
                issue = 1'b1;
                stage = 1'b1;
                op_d  = op_q + 2'd1;
                if (op_q == 2'd3) state_d = W1;
            end
            // completion is reported one cycle after the last S1 issue; any
            // remaining S1 write-back drains from the delay pipe on its own
            W1: begin
                busy = stall;
                if (!stall) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // op addresses and twiddle exponents for the op being issued
    always_comb begin
        g4       = {2'b00, op_q};
        e_b      = '0;
        e_c      = '0;
        e_d      = '0;
        iss_addr = '0;
        if (state_q == S0) begin
            iss_addr = {2'b11, op_q, 2'b10, op_q, 2'b01, op_q, 2'b00, op_q};
            e_b      = g4;
            e_c      = 4'(g4 << 1);
            e_d      = 4'(g4 + 4'(g4 << 1));
        end else if (state_q == S1) begin
            iss_addr = {op_q, 2'b11, op_q, 2'b10, op_q, 2'b01, op_q, 2'b00};
        end
        rd_en   = issue;
        rd_addr = issue ? iss_addr : 16'h0;
        tw_exp  = issue ? {tw_fix(e_d, inv_q), tw_fix(e_c, inv_q), tw_fix(e_b, inv_q)}
                        : 12'h0;
        last_s0 = issue && (state_q == S0) && (op_q == 2'd3);
    end

    // delay pipe: shifts only when not stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            addr_pipe <= '0;
        end else if (!stall) begin
            vld_pipe[1]  <= issue;
            last_pipe[1] <= last_s0;
            addr_pipe[1] <= rd_addr;
            for (int k = 2; k <= BF_LAT; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                last_pipe[k] <= last_pipe[k-1];
                addr_pipe[k] <= addr_pipe[k-1];
            end
        end
    end

    assign wr_en   = vld_pipe[BF_LAT] && !stall;
    assign wr_addr = wr_en ? addr_pipe[BF_LAT] : 16'h0;

endmodule
